// File: rtl/proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : proc_io_bridge
// Purpose  : I/O bridge between the floating-point soft processor and its
//            external channels. Each input channel is buffered by a
//            valid/ready FIFO that the processor drains by address. Each
//            output channel holds one registered word with a valid/ready
//            handshake. Sticky flags report empty reads (underrun),
//            overwritten unacknowledged words (overflow) and accesses to
//            channels that do not exist (addr_err).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous reset, active low
//   in_data      in   NCH_IN words, channel k at [k*NBW +: NBW]
//   in_valid     in   per-channel producer valid
//   in_ready     out  per-channel FIFO not full (from registered count)
//   proc_req_in  in   processor read request
//   addr_in      in   input channel selected for reading
//   proc_dout    out  FIFO head, or last popped word when empty (comb.)
//   req_in       out  one-hot decode of proc_req_in by addr_in
//   proc_out_en  in   processor write strobe
//   addr_out     in   output channel selected for writing
//   proc_din     in   word written by the processor
//   out_en       out  one-hot decode of proc_out_en by addr_out
//   out_data     out  registered per-channel output words
//   out_valid    out  per-channel word pending
//   out_ready    in   per-channel consumer ready
//   clr_flags    in   clears all sticky flags at the edge
//   underrun     out  sticky, per input channel
//   overflow     out  sticky, per output channel
//   addr_err     out  sticky, out-of-range channel address
// ============================================================================
module proc_io_bridge #(
  parameter int NBW     = 28,
  parameter int NCH_IN  = 4,
  parameter int NCH_OUT = 4,
  parameter int FDEPTH  = 4,   // power of two, >= 2
  parameter int NBAI    = 2,   // >= max(1, clog2(NCH_IN))
  parameter int NBAO    = 2    // >= max(1, clog2(NCH_OUT))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH_IN*NBW-1:0]   in_data,
  input  logic [NCH_IN-1:0]       in_valid,
  output logic [NCH_IN-1:0]       in_ready,
  input  logic                    proc_req_in,
  input  logic [NBAI-1:0]         addr_in,
  output logic [NBW-1:0]          proc_dout,
  output logic [NCH_IN-1:0]       req_in,
  input  logic                    proc_out_en,
  input  logic [NBAO-1:0]         addr_out,
  input  logic [NBW-1:0]          proc_din,
  output logic [NCH_OUT-1:0]      out_en,
  output logic [NCH_OUT*NBW-1:0]  out_data,
  output logic [NCH_OUT-1:0]      out_valid,
  input  logic [NCH_OUT-1:0]      out_ready,
  input  logic                    clr_flags,
  output logic [NCH_IN-1:0]       underrun,
  output logic [NCH_OUT-1:0]      overflow,
  output logic                    addr_err
);

  localparam int          PW       = $clog2(FDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FDEPTH);

  logic                in_addr_ok;
  logic                out_addr_ok;
  logic [NBW-1:0]      head [NCH_IN];
  logic [NCH_IN-1:0]   unr_evt;
  logic [NCH_OUT-1:0]  ovf_evt;
  logic                aerr_evt;

  logic [NCH_IN-1:0]   underrun_q, underrun_d;
  logic [NCH_OUT-1:0]  overflow_q, overflow_d;
  logic                addr_err_q, addr_err_d;

  assign in_addr_ok  = (int'(addr_in)  < NCH_IN);
  assign out_addr_ok = (int'(addr_out) < NCH_OUT);

  // --------------------------------------------------------------------------
  // Input channels: one FIFO each, plus the last word popped so that an empty
  // read still returns something meaningful to the processor.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NCH_IN; k++) begin : g_in
    logic           sel;
    logic           push;
    logic           pop;
    logic [PW:0]    cnt_q;
    logic [PW-1:0]  wptr_q;
    logic [PW-1:0]  rptr_q;
    logic [NBW-1:0] last_q;
    logic [NBW-1:0] mem_q [FDEPTH];

    assign sel         = proc_req_in && (int'(addr_in) == k);
    assign req_in[k]   = sel;
    // Full is judged on the registered count only, so a full FIFO never
    // accepts a push in the same cycle as a pop.
    assign in_ready[k] = (cnt_q != FULL_CNT);
    assign push        = in_valid[k] & in_ready[k];
    // An empty read never bypasses a same-cycle push: it is an underrun.
    assign pop         = sel & (cnt_q != '0);
    assign unr_evt[k]  = sel & (cnt_q == '0);
    assign head[k]     = (cnt_q != '0) ? mem_q[rptr_q] : last_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        last_q <= '0;
      end else begin
        // Pointers are exactly PW bits wide, so they wrap modulo FDEPTH.
        if (push) begin
          wptr_q <= wptr_q + PW'(1);
        end
        if (pop) begin
          rptr_q <= rptr_q + PW'(1);
          last_q <= mem_q[rptr_q];
        end
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
          2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Storage needs no reset: contents are only visible while cnt_q is
    // non-zero, and reset clears the count.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wptr_q] <= in_data[k*NBW +: NBW];
      end
    end
  end

  // Out-of-range addresses match no channel and leave proc_dout at zero.
  always_comb begin
    proc_dout = '0;
    for (int k = 0; k < NCH_IN; k++) begin
      if (int'(addr_in) == k) begin
        proc_dout = head[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output channels: a single holding register per channel. A processor
  // write always wins; it only counts as an overflow when the pending word
  // is not being taken in that same cycle.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NCH_OUT; j++) begin : g_out
    logic           sel;
    logic [NBW-1:0] data_q;
    logic           valid_q;

    assign sel        = proc_out_en && (int'(addr_out) == j);
    assign out_en[j]  = sel;
    assign ovf_evt[j] = sel & valid_q & ~out_ready[j];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (sel) begin
        data_q  <= proc_din;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready[j]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_data[j*NBW +: NBW] = data_q;
    assign out_valid[j]           = valid_q;
  end

  // --------------------------------------------------------------------------
  // Sticky flags: a new event in the clearing cycle takes priority.
  // --------------------------------------------------------------------------
  assign aerr_evt = (proc_req_in & ~in_addr_ok) | (proc_out_en & ~out_addr_ok);

  assign underrun_d = (underrun_q & ~{NCH_IN{clr_flags}})  | unr_evt;
  assign overflow_d = (overflow_q & ~{NCH_OUT{clr_flags}}) | ovf_evt;
  assign addr_err_d = (addr_err_q & ~clr_flags)            | aerr_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_q <= '0;
      overflow_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign underrun = underrun_q;
  assign overflow = overflow_q;
  assign addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_io_bridge
// Purpose  : Self-checking bench for proc_io_bridge (3 input channels,
//            4 output channels, 3-bit output address so that both address
//            ranges have unused codes). A table of hand-computed vectors
//            covers the directed scenarios; random traffic is then checked
//            against a queue-based behavioural model; finally an
//            asynchronous reset is asserted mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_io_bridge;

  localparam int NBW = 28;
  localparam int NI  = 3;
  localparam int NO  = 4;
  localparam int FD  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NI*NBW-1:0]   in_data;
  logic [NI-1:0]       in_valid, in_ready, req_in, underrun;
  logic                proc_req_in, proc_out_en, clr_flags, addr_err;
  logic [1:0]          addr_in;
  logic [2:0]          addr_out;
  logic [NBW-1:0]      proc_dout, proc_din;
  logic [NO-1:0]       out_en, out_valid, out_ready, overflow;
  logic [NO*NBW-1:0]   out_data;

  proc_io_bridge #(
    .NBW(NBW), .NCH_IN(NI), .NCH_OUT(NO), .FDEPTH(FD), .NBAI(2), .NBAO(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_dout(proc_dout),
    .req_in(req_in),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_din(proc_din),
    .out_en(out_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_flags(clr_flags), .underrun(underrun), .overflow(overflow),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  logic [NBW-1:0] mq [NI][$];
  logic [NBW-1:0] mlast [NI];
  logic [NBW-1:0] mod [NO];
  logic [NO-1:0]  movld;
  logic [NI-1:0]  munr;
  logic [NO-1:0]  movf;
  logic           maerr;

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      mlast[k] = '0;
    end
    for (int j = 0; j < NO; j++) mod[j] = '0;
    movld = '0; munr = '0; movf = '0; maerr = 1'b0;
  endfunction

  // Applies one clock edge with the inputs currently driven.
  function automatic void model_edge();
    logic [NI-1:0] ue;
    logic [NO-1:0] oe;
    logic          ae;
    ue = '0; oe = '0; ae = 1'b0;
    for (int k = 0; k < NI; k++) begin
      bit room;
      room = (mq[k].size() < FD);
      if (proc_req_in && int'(addr_in) == k) begin
        if (mq[k].size() != 0) mlast[k] = mq[k].pop_front();
        else ue[k] = 1'b1;
      end
      if (in_valid[k] && room) mq[k].push_back(in_data[k*NBW +: NBW]);
    end
    if (proc_req_in && int'(addr_in) >= NI) ae = 1'b1;
    if (proc_out_en && int'(addr_out) >= NO) ae = 1'b1;
    for (int j = 0; j < NO; j++) begin
      if (proc_out_en && int'(addr_out) == j) begin
        if (movld[j] && !out_ready[j]) oe[j] = 1'b1;
        mod[j]   = proc_din;
        movld[j] = 1'b1;
      end else if (movld[j] && out_ready[j]) begin
        movld[j] = 1'b0;
      end
    end
    if (clr_flags) begin
      munr = '0; movf = '0; maerr = 1'b0;
    end
    munr  = munr | ue;
    movf  = movf | oe;
    maerr = maerr | ae;
  endfunction

  function automatic logic [NBW-1:0] exp_dout();
    int a;
    a = int'(addr_in);
    if (a >= NI) return '0;
    if (mq[a].size() != 0) return mq[a][0];
    return mlast[a];
  endfunction

  function automatic logic [NI-1:0] exp_req();
    if (proc_req_in && int'(addr_in) < NI) return NI'(1) << addr_in;
    return '0;
  endfunction

  function automatic logic [NO-1:0] exp_oen();
    if (proc_out_en && int'(addr_out) < NO) return NO'(1) << addr_out;
    return '0;
  endfunction

  function automatic logic [NI-1:0] exp_rdy();
    logic [NI-1:0] r;
    for (int k = 0; k < NI; k++) r[k] = (mq[k].size() < FD);
    return r;
  endfunction

  function automatic logic [NO*NBW-1:0] exp_odata();
    logic [NO*NBW-1:0] d;
    for (int j = 0; j < NO; j++) d[j*NBW +: NBW] = mod[j];
    return d;
  endfunction

  // One cycle checked against the model; called at posedge+1.
  task automatic step_model(input string tag);
    #1;
    chk({tag, " dout"}, proc_dout, exp_dout());
    chk({tag, " req_in"}, req_in, exp_req());
    chk({tag, " out_en"}, out_en, exp_oen());
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, " in_ready"}, in_ready, exp_rdy());
    chk({tag, " out_valid"}, out_valid, movld);
    chk({tag, " out_data"}, out_data, exp_odata());
    chk({tag, " underrun"}, underrun, munr);
    chk({tag, " overflow"}, overflow, movf);
    chk({tag, " addr_err"}, addr_err, maerr);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [2:0]     vld;  logic [NBW-1:0] idata;
    logic           req;  logic [1:0]     ain;
    logic           oen;  logic [2:0]     aout;
    logic [NBW-1:0] din;  logic [3:0]     ordy;  logic clr;
    logic [NBW-1:0] e_dout; logic [2:0] e_req; logic [3:0] e_oen;
    logic [2:0]     e_rdy;  logic [3:0] e_ovld; logic [2:0] e_unr;
    logic [3:0]     e_ovf;  logic       e_aerr; logic [NBW-1:0] e_od3;
  } vec_t;

  function automatic vec_t v(
    logic [2:0] vld, logic [NBW-1:0] idata, logic req, logic [1:0] ain,
    logic oen, logic [2:0] aout, logic [NBW-1:0] din, logic [3:0] ordy,
    logic clr, logic [NBW-1:0] e_dout, logic [2:0] e_req, logic [3:0] e_oen,
    logic [2:0] e_rdy, logic [3:0] e_ovld, logic [2:0] e_unr,
    logic [3:0] e_ovf, logic e_aerr, logic [NBW-1:0] e_od3);
    vec_t t;
    t.vld = vld; t.idata = idata; t.req = req; t.ain = ain; t.oen = oen;
    t.aout = aout; t.din = din; t.ordy = ordy; t.clr = clr;
    t.e_dout = e_dout; t.e_req = e_req; t.e_oen = e_oen; t.e_rdy = e_rdy;
    t.e_ovld = e_ovld; t.e_unr = e_unr; t.e_ovf = e_ovf; t.e_aerr = e_aerr;
    t.e_od3 = e_od3;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    in_valid = t.vld;   in_data  = {NI{t.idata}};
    proc_req_in = t.req; addr_in = t.ain;
    proc_out_en = t.oen; addr_out = t.aout; proc_din = t.din;
    out_ready = t.ordy;  clr_flags = t.clr;
  endtask

  localparam logic [NBW-1:0] A  = 28'h3F80000, B  = 28'h4000000, C  = 28'h4040000;
  localparam logic [NBW-1:0] W0 = 28'h1000001, W1 = 28'h1000002, W2 = 28'h1000003;
  localparam logic [NBW-1:0] W3 = 28'h1000004, W4 = 28'h1000005, W5 = 28'h1000006;
  localparam logic [NBW-1:0] X  = 28'h2ABCDEF;
  localparam logic [NBW-1:0] Y1 = 28'h5000001, Y2 = 28'h5000002, Y3 = 28'h5000003;
  localparam logic [NBW-1:0] Y4 = 28'h5000004;

  vec_t tv [32];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //      vld     data req ain oen aout din ordy clr | dout req  oen  | rdy  ovld unr  ovf  ae od3
    tv[0]  = v(3'b100, A,  0, 2, 0, 0, 0,  4'h0, 0,  0,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[1]  = v(3'b100, B,  0, 2, 0, 0, 0,  4'h0, 0,  A,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[2]  = v(3'b100, C,  0, 2, 0, 0, 0,  4'h0, 0,  A,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[3]  = v(3'b000, 0,  1, 2, 0, 0, 0,  4'h0, 0,  A,  3'b100, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[4]  = v(3'b000, 0,  1, 2, 0, 0, 0,  4'h0, 0,  B,  3'b100, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[5]  = v(3'b000, 0,  1, 2, 0, 0, 0,  4'h0, 0,  C,  3'b100, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[6]  = v(3'b001, W0, 0, 0, 0, 0, 0,  4'h0, 0,  0,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[7]  = v(3'b001, W1, 0, 0, 0, 0, 0,  4'h0, 0,  W0, 3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[8]  = v(3'b001, W2, 0, 0, 0, 0, 0,  4'h0, 0,  W0, 3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[9]  = v(3'b001, W3, 0, 0, 0, 0, 0,  4'h0, 0,  W0, 3'b000, 4'h0, 3'b110, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[10] = v(3'b001, W4, 0, 0, 0, 0, 0,  4'h0, 0,  W0, 3'b000, 4'h0, 3'b110, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[11] = v(3'b000, 0,  1, 0, 0, 0, 0,  4'h0, 0,  W0, 3'b001, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[12] = v(3'b001, W5, 1, 0, 0, 0, 0,  4'h0, 0,  W1, 3'b001, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[13] = v(3'b000, 0,  1, 0, 0, 0, 0,  4'h0, 0,  W2, 3'b001, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[14] = v(3'b000, 0,  1, 0, 0, 0, 0,  4'h0, 0,  W3, 3'b001, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[15] = v(3'b000, 0,  1, 0, 0, 0, 0,  4'h0, 0,  W5, 3'b001, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[16] = v(3'b000, 0,  0, 0, 0, 0, 0,  4'h0, 0,  W5, 3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[17] = v(3'b010, X,  0, 1, 0, 0, 0,  4'h0, 0,  0,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[18] = v(3'b000, 0,  1, 1, 0, 0, 0,  4'h0, 0,  X,  3'b010, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[19] = v(3'b000, 0,  1, 1, 0, 0, 0,  4'h0, 0,  X,  3'b010, 4'h0, 3'b111, 4'h0, 3'b010, 4'h0, 0, 0);
    tv[20] = v(3'b000, 0,  0, 1, 0, 0, 0,  4'h0, 1,  X,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[21] = v(3'b000, 0,  1, 1, 0, 0, 0,  4'h0, 1,  X,  3'b010, 4'h0, 3'b111, 4'h0, 3'b010, 4'h0, 0, 0);
    tv[22] = v(3'b000, 0,  0, 1, 0, 0, 0,  4'h0, 1,  X,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, 0);
    tv[23] = v(3'b000, 0,  0, 1, 1, 3, Y1, 4'h0, 0,  X,  3'b000, 4'h8, 3'b111, 4'h8, 3'b000, 4'h0, 0, Y1);
    tv[24] = v(3'b000, 0,  0, 1, 1, 3, Y2, 4'h0, 0,  X,  3'b000, 4'h8, 3'b111, 4'h8, 3'b000, 4'h8, 0, Y2);
    tv[25] = v(3'b000, 0,  0, 1, 0, 0, 0,  4'h0, 1,  X,  3'b000, 4'h0, 3'b111, 4'h8, 3'b000, 4'h0, 0, Y2);
    tv[26] = v(3'b000, 0,  0, 1, 1, 3, Y3, 4'h8, 0,  X,  3'b000, 4'h8, 3'b111, 4'h8, 3'b000, 4'h0, 0, Y3);
    tv[27] = v(3'b000, 0,  0, 1, 0, 0, 0,  4'h8, 0,  X,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, Y3);
    tv[28] = v(3'b000, 0,  1, 3, 0, 0, 0,  4'h0, 0,  0,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 1, Y3);
    tv[29] = v(3'b000, 0,  0, 3, 0, 0, 0,  4'h0, 1,  0,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, Y3);
    tv[30] = v(3'b000, 0,  0, 1, 1, 5, Y4, 4'h0, 0,  X,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 1, Y3);
    tv[31] = v(3'b000, 0,  0, 1, 0, 0, 0,  4'h0, 1,  X,  3'b000, 4'h0, 3'b111, 4'h0, 3'b000, 4'h0, 0, Y3);

    // ------------------------------------------------ reset values
    rst = 1'b0;
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #2;
    chk("reset in_ready", in_ready, 3'b111);
    chk("reset out_valid", out_valid, 4'h0);
    chk("reset out_data", out_data, '0);
    chk("reset proc_dout", proc_dout, '0);
    chk("reset flags", {underrun, overflow, addr_err}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ------------------------------------------------ directed table
    for (int i = 0; i < 32; i++) begin
      apply(tv[i]);
      #1;
      chk($sformatf("v%0d dout", i), proc_dout, tv[i].e_dout);
      chk($sformatf("v%0d req_in", i), req_in, tv[i].e_req);
      chk($sformatf("v%0d out_en", i), out_en, tv[i].e_oen);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("v%0d out_valid", i), out_valid, tv[i].e_ovld);
      chk($sformatf("v%0d underrun", i), underrun, tv[i].e_unr);
      chk($sformatf("v%0d overflow", i), overflow, tv[i].e_ovf);
      chk($sformatf("v%0d addr_err", i), addr_err, tv[i].e_aerr);
      chk($sformatf("v%0d out_data3", i), out_data[3*NBW +: NBW], tv[i].e_od3);
    end

    // ------------------------------------------------ random vs model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NI; k++) begin
        in_data[k*NBW +: NBW] = NBW'($urandom);
        in_valid[k] = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      proc_req_in = ($urandom_range(0, 3) != 0);
      addr_in     = 2'($urandom_range(0, 3));
      proc_out_en = $urandom_range(0, 1) == 1;
      addr_out    = 3'($urandom_range(0, 4));
      proc_din    = NBW'($urandom);
      out_ready   = 4'($urandom);
      clr_flags   = ($urandom_range(0, 15) == 0);
      step_model($sformatf("r%0d", i));
    end

    // ------------------------------------------------ mid-stream reset
    apply(v(3'b001, W0, 0, 0, 1, 0, Y1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step_model("m0");
    apply(v(3'b001, W1, 1, 3, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step_model("m1");
    apply(v(3'b000, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-reset out_valid0", out_valid[0], 1'b1);
    chk("pre-reset addr_err", addr_err, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset in_ready", in_ready, 3'b111);
    chk("async reset out_valid", out_valid, 4'h0);
    chk("async reset out_data", out_data, '0);
    chk("async reset proc_dout", proc_dout, '0);
    chk("async reset flags", {underrun, overflow, addr_err}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(v(3'b000, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step_model("post0");
    apply(v(3'b000, 0, 0, 2, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step_model("post1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
